// File: rtl/trig_io_pkg.sv
// ============================================================================
//  Module      : trig_io_pkg
//  Description : Shared types and constants for the trigger I/O engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trig_io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } trig_state_e;

    localparam int SYNC_STAGES = 2;
    localparam int FILT_LEN    = 3;

    // Pin-to-edge-detect latency; the capture holds ts_now of that cycle.
    localparam int c_in_lat_nofilt = 3;
    localparam int c_in_lat_filt   = 5;

endpackage

`default_nettype wire

// File: rtl/trig_out_chan.sv
// ============================================================================
//  Module      : trig_out_chan
//  Description : One programmable trigger output: delay, then pulse of width W.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trig_out_chan
    import trig_io_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_delay,
    input  logic [CNT_W-1:0] i_width,
    output logic             o_trig,
    output logic             o_busy
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    trig_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_width;
    logic             r_trig;
    logic             r_busy;

    // r_cnt holds the cycles remaining in the current phase minus one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_width <= '0;
            r_trig  <= 1'b0;
            r_busy  <= 1'b0;
        end else if (i_abort) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_trig  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_width <= i_width;
                        if (i_delay != '0) begin
                            r_state <= DELAY;
                            r_busy  <= 1'b1;
                            r_cnt   <= i_delay - c_one;
                        end else if (i_width != '0) begin
                            r_state <= PULSE;
                            r_trig  <= 1'b1;
                            r_busy  <= 1'b1;
                            r_cnt   <= i_width - c_one;
                        end
                    end
                end
                DELAY: begin
                    if (r_cnt == '0) begin
                        if (r_width != '0) begin
                            r_state <= PULSE;
                            r_trig  <= 1'b1;
                            r_cnt   <= r_width - c_one;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                PULSE: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_trig  <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_trig  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_trig = r_trig;
    assign o_busy = r_busy;

endmodule

`default_nettype wire

// File: rtl/trig_io_ctrl.sv
// ============================================================================
//  Module      : trig_io_ctrl
//  Description : N_OUT programmable trigger pulse generators and N_IN
//                timestamped trigger input captures. Optional input glitch
//                filter enabled by defining TRIG_IN_FILTER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trig_io_ctrl
    import trig_io_pkg::*;
#(
    parameter int N_OUT = 3,
    parameter int N_IN  = 2,
    parameter int CNT_W = 16,
    parameter int TS_W  = 32
) (
    input  logic                  io_mainClk,
    input  logic                  io_asyncReset_n,
    input  logic [N_OUT-1:0]      start,
    input  logic [N_OUT-1:0]      abort,
    input  logic [N_OUT*CNT_W-1:0] cfg_delay,
    input  logic [N_OUT*CNT_W-1:0] cfg_width,
    output logic [N_OUT-1:0]      trigs_out,
    output logic [N_OUT-1:0]      out_busy,
    input  logic [N_IN-1:0]       trigs_in,
    input  logic [N_IN-1:0]       cap_clr,
    input  logic                  ts_clr,
    output logic [TS_W-1:0]       ts_now,
    output logic [N_IN*TS_W-1:0]  cap_ts,
    output logic [N_IN-1:0]       cap_valid,
    output logic [N_IN-1:0]       cap_ovf
);

    localparam logic [TS_W-1:0] c_ts_one = TS_W'(1);

    logic [TS_W-1:0] r_ts;

    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) r_ts <= '0;
        else if (ts_clr)      r_ts <= '0;
        else                  r_ts <= r_ts + c_ts_one;
    end

    assign ts_now = r_ts;

    for (genvar i = 0; i < N_OUT; i++) begin : g_out
        trig_out_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .i_clk   (io_mainClk),
            .i_rst_n (io_asyncReset_n),
            .i_start (start[i]),
            .i_abort (abort[i]),
            .i_delay (cfg_delay[i*CNT_W +: CNT_W]),
            .i_width (cfg_width[i*CNT_W +: CNT_W]),
            .o_trig  (trigs_out[i]),
            .o_busy  (out_busy[i])
        );
    end

    for (genvar j = 0; j < N_IN; j++) begin : g_in
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_level;
        logic                   w_rise;
        logic                   r_edge;
        logic                   r_valid;
        logic                   r_ovf;
        logic [TS_W-1:0]        r_cap;

        assign w_level = r_sync[SYNC_STAGES-1];

        always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
            if (!io_asyncReset_n) r_sync <= '0;
            else                  r_sync <= {r_sync[SYNC_STAGES-2:0], trigs_in[j]};
        end

`ifdef TRIG_IN_FILTER_EN
        // Accepted level flips only once FILT_LEN consecutive samples agree.
        logic [FILT_LEN-2:0] r_hist;
        logic                r_filt;
        logic                w_all1;
        logic                w_all0;

        assign w_all1 = &{r_hist, w_level};
        assign w_all0 = ~|{r_hist, w_level};
        assign w_rise = w_all1 & ~r_filt;

        always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
            if (!io_asyncReset_n) begin
                r_hist <= '0;
                r_filt <= 1'b0;
            end else begin
                r_hist <= {r_hist[FILT_LEN-3:0], w_level};
                if (w_all1)      r_filt <= 1'b1;
                else if (w_all0) r_filt <= 1'b0;
            end
        end
`else
        logic r_prev;

        assign w_rise = w_level & ~r_prev;

        always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
            if (!io_asyncReset_n) r_prev <= 1'b0;
            else                  r_prev <= w_level;
        end
`endif

        // A fresh edge beats a same-cycle clear; the first capture is kept on overflow.
        always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
            if (!io_asyncReset_n) begin
                r_edge  <= 1'b0;
                r_valid <= 1'b0;
                r_ovf   <= 1'b0;
                r_cap   <= '0;
            end else begin
                r_edge <= w_rise;
                if (r_edge) begin
                    if (!r_valid || cap_clr[j]) begin
                        r_cap   <= r_ts;
                        r_valid <= 1'b1;
                        r_ovf   <= 1'b0;
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end else if (cap_clr[j]) begin
                    r_valid <= 1'b0;
                    r_ovf   <= 1'b0;
                end
            end
        end

        assign cap_ts[j*TS_W +: TS_W] = r_cap;
        assign cap_valid[j]           = r_valid;
        assign cap_ovf[j]             = r_ovf;
    end

endmodule

`default_nettype wire

// File: tb/tb_trig_io_ctrl.sv
// ============================================================================
//  Module      : tb_trig_io_ctrl
//  Description : Directed self-checking bench for trig_io_ctrl (8-bit timestamp
//                so that counter wrap is reachable).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trig_io_ctrl;

    localparam int N_OUT = 3;
    localparam int N_IN  = 2;
    localparam int CNT_W = 16;
    localparam int TS_W  = 8;
`ifdef TRIG_IN_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [N_OUT-1:0]         start;
    logic [N_OUT-1:0]         abort;
    logic [N_OUT*CNT_W-1:0]   cfg_delay;
    logic [N_OUT*CNT_W-1:0]   cfg_width;
    logic [N_OUT-1:0]         trigs_out;
    logic [N_OUT-1:0]         out_busy;
    logic [N_IN-1:0]          trigs_in;
    logic [N_IN-1:0]          cap_clr;
    logic                     ts_clr;
    logic [TS_W-1:0]          ts_now;
    logic [N_IN*TS_W-1:0]     cap_ts;
    logic [N_IN-1:0]          cap_valid;
    logic [N_IN-1:0]          cap_ovf;

    int              checks   = 0;
    int              failures = 0;
    logic [TS_W-1:0] ts_model = '0;
    logic [TS_W-1:0] p;
    logic [TS_W-1:0] rise_ts;

    trig_io_ctrl #(
        .N_OUT (N_OUT),
        .N_IN  (N_IN),
        .CNT_W (CNT_W),
        .TS_W  (TS_W)
    ) dut (
        .io_mainClk      (clk),
        .io_asyncReset_n (rst_n),
        .start           (start),
        .abort           (abort),
        .cfg_delay       (cfg_delay),
        .cfg_width       (cfg_width),
        .trigs_out       (trigs_out),
        .out_busy        (out_busy),
        .trigs_in        (trigs_in),
        .cap_clr         (cap_clr),
        .ts_clr          (ts_clr),
        .ts_now          (ts_now),
        .cap_ts          (cap_ts),
        .cap_valid       (cap_valid),
        .cap_ovf         (cap_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; ts_model follows the counter's documented behaviour.
    task automatic tick();
        if (rst_n) ts_model = ts_clr ? '0 : ts_model + TS_W'(1);
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_ts(input logic [TS_W-1:0] target);
        for (int k = 0; k < 600 && ts_model != target; k++) tick();
        check("wait_ts", ts_now, target);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = '0;
        abort     = '0;
        cfg_delay = '0;
        cfg_width = '0;
        trigs_in  = '0;
        cap_clr   = '0;
        ts_clr    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_trig",  trigs_out, 0);
        check("rst_busy",  out_busy,  0);
        check("rst_ts",    ts_now,    0);
        check("rst_capts", cap_ts,    0);
        check("rst_valid", cap_valid, 0);
        check("rst_ovf",   cap_ovf,   0);
        rst_n    = 1'b1;
        ts_model = '0;
        ticks(5);
        check("ts_run", ts_now, 5);

        // ch0: D=4 W=3; cfg changed right after start must not matter
        cfg_delay[0*CNT_W +: CNT_W] = 16'd4;
        cfg_width[0*CNT_W +: CNT_W] = 16'd3;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        cfg_delay[0*CNT_W +: CNT_W] = 16'd1;
        cfg_width[0*CNT_W +: CNT_W] = 16'd9;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("c0_trig_t%0d", k), trigs_out[0], (k >= 5 && k <= 7) ? 1 : 0);
            check($sformatf("c0_busy_t%0d", k), out_busy[0],  (k <= 7) ? 1 : 0);
            tick();
        end

        // ch0: start together with abort in IDLE starts nothing
        cfg_delay[0*CNT_W +: CNT_W] = 16'd0;
        cfg_width[0*CNT_W +: CNT_W] = 16'd2;
        start[0] = 1'b1;
        abort[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        abort[0] = 1'b0;
        check("c0_startabort_busy", out_busy[0], 0);
        check("c0_startabort_trig", trigs_out[0], 0);

        // ch1: D=0 W=1, second start one cycle later is ignored
        cfg_delay[1*CNT_W +: CNT_W] = 16'd0;
        cfg_width[1*CNT_W +: CNT_W] = 16'd1;
        start[1] = 1'b1;
        tick();
        check("c1_trig_t1", trigs_out[1], 1);
        check("c1_busy_t1", out_busy[1],  1);
        tick();
        start[1] = 1'b0;
        check("c1_trig_t2", trigs_out[1], 0);
        check("c1_busy_t2", out_busy[1],  0);
        tick();
        check("c1_trig_t3", trigs_out[1], 0);
        check("c1_busy_t3", out_busy[1],  0);

        // ch2: D=10 W=5, abort in second pulse cycle
        cfg_delay[2*CNT_W +: CNT_W] = 16'd10;
        cfg_width[2*CNT_W +: CNT_W] = 16'd5;
        start[2] = 1'b1;
        tick();
        start[2] = 1'b0;
        check("c2_trig_t1", trigs_out[2], 0);
        ticks(10);
        check("c2_trig_t11", trigs_out[2], 1);
        tick();
        check("c2_trig_t12", trigs_out[2], 1);
        abort[2] = 1'b1;
        tick();
        abort[2] = 1'b0;
        check("c2_abort_trig", trigs_out[2], 0);
        check("c2_abort_busy", out_busy[2],  0);
        tick();
        check("c2_after_abort_busy", out_busy[2], 0);

        // ch2: W=0 D=2 -> busy two cycles, never high
        cfg_delay[2*CNT_W +: CNT_W] = 16'd2;
        cfg_width[2*CNT_W +: CNT_W] = 16'd0;
        start[2] = 1'b1;
        tick();
        start[2] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("c2_w0_busy_t%0d", k), out_busy[2],  (k <= 2) ? 1 : 0);
            check($sformatf("c2_w0_trig_t%0d", k), trigs_out[2], 0);
            tick();
        end

        // ch2: abort in DELAY -> no pulse later
        cfg_delay[2*CNT_W +: CNT_W] = 16'd5;
        cfg_width[2*CNT_W +: CNT_W] = 16'd2;
        start[2] = 1'b1;
        tick();
        start[2] = 1'b0;
        tick();
        abort[2] = 1'b1;
        tick();
        abort[2] = 1'b0;
        check("c2_dabort_busy", out_busy[2], 0);
        for (int k = 0; k < 8; k++) begin
            check("c2_dabort_trig", trigs_out[2], 0);
            tick();
        end

        // ts_clr, then capture an edge at ts_now=100
        ts_clr = 1'b1;
        tick();
        ts_clr = 1'b0;
        check("ts_clr", ts_now, 0);
        wait_ts(8'd100);
        trigs_in[0] = 1'b1;
        ticks(LAT);
        check("cap0_not_yet", cap_valid[0], 0);
        tick();
        check("cap0_valid",  cap_valid[0], 1);
        check("cap0_ts",     cap_ts[0*TS_W +: TS_W], 100 + LAT);
        check("cap0_ovf",    cap_ovf[0], 0);
        check("cap1_indep",  cap_valid[1], 0);
        trigs_in[0] = 1'b0;
        ticks(6);
        trigs_in[0] = 1'b1;
        ticks(LAT + 3);
        check("cap0_ovf2",   cap_ovf[0], 1);
        check("cap0_keep",   cap_ts[0*TS_W +: TS_W], 100 + LAT);
        check("cap0_valid2", cap_valid[0], 1);
        trigs_in[0] = 1'b0;
        ticks(6);
        cap_clr[0] = 1'b1;
        tick();
        cap_clr[0] = 1'b0;
        check("cap0_clr_valid", cap_valid[0], 0);
        check("cap0_clr_ovf",   cap_ovf[0],   0);

        // ts_clr coincident with edge-detect captures pre-clear value
        p = ts_model;
        trigs_in[0] = 1'b1;
        ticks(LAT);
        ts_clr = 1'b1;
        tick();
        ts_clr = 1'b0;
        check("tsclr_edge_cap", cap_ts[0*TS_W +: TS_W], p + TS_W'(LAT));
        check("tsclr_edge_ts",  ts_now, 0);
        trigs_in[0] = 1'b0;
        ticks(6);

        // counter wrap
        wait_ts(8'd254);
        tick();
        check("ts_255", ts_now, 255);
        tick();
        check("ts_wrap0", ts_now, 0);

        // ch1 edge whose detect cycle lands at ts_now=1 after the wrap
        rise_ts = 8'd1 - TS_W'(LAT);
        wait_ts(rise_ts);
        trigs_in[1] = 1'b1;
        ticks(LAT + 1);
        check("cap1_wrap_valid", cap_valid[1], 1);
        check("cap1_wrap_ts",    cap_ts[1*TS_W +: TS_W], 1);
        trigs_in[1] = 1'b0;
        ticks(6);
        trigs_in[1] = 1'b1;
        ticks(LAT + 2);
        check("cap1_ovf", cap_ovf[1], 1);
        trigs_in[1] = 1'b0;
        ticks(6);

        // cap_clr coincident with edge: edge wins
        p = ts_model;
        trigs_in[1] = 1'b1;
        ticks(LAT);
        cap_clr[1] = 1'b1;
        tick();
        cap_clr[1] = 1'b0;
        check("clr_edge_valid", cap_valid[1], 1);
        check("clr_edge_ovf",   cap_ovf[1],   0);
        check("clr_edge_ts",    cap_ts[1*TS_W +: TS_W], p + TS_W'(LAT));
        trigs_in[1] = 1'b0;
        ticks(6);

        // async reset mid-pulse and mid-capture
        cap_clr[0] = 1'b1;
        tick();
        cap_clr[0] = 1'b0;
        cfg_delay[0*CNT_W +: CNT_W] = 16'd0;
        cfg_width[0*CNT_W +: CNT_W] = 16'd20;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        trigs_in[0] = 1'b1;
        ticks(2);
        check("pre_rst_trig", trigs_out[0], 1);
        #2;
        rst_n    = 1'b0;
        trigs_in = '0;
        #1;
        check("arst_trig",  trigs_out, 0);
        check("arst_busy",  out_busy,  0);
        check("arst_valid", cap_valid, 0);
        check("arst_ovf",   cap_ovf,   0);
        check("arst_capts", cap_ts,    0);
        check("arst_ts",    ts_now,    0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        ts_model = '0;
        for (int k = 0; k < 30; k++) begin
            tick();
            check("post_rst_trig",  trigs_out, 0);
            check("post_rst_busy",  out_busy,  0);
            check("post_rst_valid", cap_valid, 0);
        end
        check("post_rst_ts", ts_now, 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
